alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 53 +++++
 rtl/regfile4x8.sv | 31 +++
 rtl/alu_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer.
// State enum, opcodes, instruction field layout and decoder.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NOT  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_SRA  = 3'd4;
  localparam logic [2:0] OP_SLL  = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_BNEQ = 3'd7;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 11;
  localparam int RS_MSB  = 10;
  localparam int RS_LSB  = 9;
  localparam int RT_MSB  = 8;
  localparam int RT_LSB  = 7;
  localparam int OFF_MSB = 6;
  localparam int OFF_LSB = 0;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [6:0] off;
  } instr_t;

  function automatic instr_t decode(
    input logic [15:0] w
  );
    instr_t d;
    d.op  = w[OP_MSB:OP_LSB];
    d.rd  = w[RD_MSB:RD_LSB];
    d.rs  = w[RS_MSB:RS_LSB];
    d.rt  = w[RT_MSB:RT_LSB];
    d.off = w[OFF_MSB:OFF_LSB];
    return d;
  endfunction

endpackage

// File: rtl/regfile4x8.sv
// Four 8-bit registers: one write port, three async read ports.
// Ports: i_we/i_waddr/i_wdata write; i_ra/i_rb/i_rc -> o_a/o_b/o_c.
module regfile4x8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_we,
  input  logic [1:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [1:0] i_ra,
  input  logic [1:0] i_rb,
  input  logic [1:0] i_rc,
  output logic [7:0] o_a,
  output logic [7:0] o_b,
  output logic [7:0] o_c
);

  logic [7:0] r_mem [4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_a = r_mem[i_ra];
  assign o_b = r_mem[i_rb];
  assign o_c = r_mem[i_rc];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer driving an external 8-bit ALU.
// Ports: fetch handshake, ALU drive/results, host preload, debug, status.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            load_en,
  input  logic [1:0]      load_addr,
  input  logic [7:0]      load_data,
  input  logic [1:0]      dbg_addr,
  output logic [7:0]      dbg_data,
  output logic [PC_W-1:0] pc,
  input  logic [15:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [2:0]      alu_sel,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  input  logic [7:0]      alu_f,
  input  logic            alu_ovf,
  input  logic            alu_take_branch,
  output logic            busy,
  output logic            done,
  output logic            ovf_flag
);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic [7:0]      r_res;
  logic            r_ovf;
  logic            r_tkn;
  logic            r_ovf_flag;

  instr_t          w_ir;
  logic            w_exec;
  logic            w_wb;
  logic            w_idle;
  logic            w_is_wr;
  logic [PC_W-1:0] w_pc1;
  logic [PC_W-1:0] w_off;
  logic [PC_W-1:0] w_tgt;
  logic            w_we;
  logic [1:0]      w_waddr;
  logic [7:0]      w_wdata;
  logic [7:0]      w_ra;
  logic [7:0]      w_rb;

  assign w_ir   = decode(r_ir);
  assign w_exec = (r_state == S_EXEC);
  assign w_wb   = (r_state == S_WB);
  assign w_idle = (r_state == S_IDLE) ||
                  (r_state == S_HALT);

  assign w_is_wr = (w_ir.op == OP_ADD) ||
                   (w_ir.op == OP_NOT) ||
                   (w_ir.op == OP_AND) ||
                   (w_ir.op == OP_OR)  ||
                   (w_ir.op == OP_SRA) ||
                   (w_ir.op == OP_SLL);

  assign w_pc1 = r_pc + PC_W'(1);
  assign w_off = PC_W'($signed(w_ir.off));
  assign w_tgt = w_pc1 + w_off;

  // Only one writer at a time: WB retire or host load when parked.
  assign w_we    = (w_wb && w_is_wr) ||
                   (w_idle && load_en);
  assign w_waddr = w_wb ? w_ir.rd : load_addr;
  assign w_wdata = w_wb ? r_res : load_data;

  regfile4x8 u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_ra    (w_ir.rs),
    .i_rb    (w_ir.rt),
    .i_rc    (dbg_addr),
    .o_a     (w_ra),
    .o_b     (w_rb),
    .o_c     (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_ir       <= '0;
      r_res      <= '0;
      r_ovf      <= 1'b0;
      r_tkn      <= 1'b0;
      r_ovf_flag <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_pc       <= '0;
            r_ovf_flag <= 1'b0;
          end
        end
        S_FETCH: begin
          if (instr_valid) begin
            r_ir    <= instr;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res   <= alu_f;
          r_ovf   <= alu_ovf;
          r_tkn   <= alu_take_branch;
          r_state <= S_WB;
        end
        S_WB: begin
          r_state <= S_FETCH;
          if (w_is_wr) begin
            r_pc <= w_pc1;
            if (w_ir.op == OP_ADD && r_ovf)
              r_ovf_flag <= 1'b1;
          end else if (r_tkn) begin
            // Branch to itself is the halt idiom.
            if (w_tgt == r_pc)
              r_state <= S_HALT;
            else
              r_pc <= w_tgt;
          end else begin
            r_pc <= w_pc1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pc          = r_pc;
  assign ovf_flag    = r_ovf_flag;
  assign instr_ready = (r_state == S_FETCH);
  assign busy        = (r_state == S_FETCH) ||
                       (r_state == S_EXEC)  ||
                       (r_state == S_WB);
  assign done        = (r_state == S_HALT);
  assign alu_sel     = w_exec ? w_ir.op : 3'd0;
  assign alu_a       = w_exec ? w_ra : 8'd0;
  assign alu_b       = w_exec ? w_rb : 8'd0;

endmodule
